collision_event_arbiter: RTL and testbench
==========================================

COLLISION_EVENT_ARBITER -- requirements
Module: collision_event_arbiter

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 16, max clk cycles event_valid waits for event_ack before the event is dropped (range 2..31).
REQ-002 Parameter: COOLDOWN_FRAMES, default 30, frames of enemy-collision immunity after an acknowledged DEATH event (range 0..63).
REQ-003 clk  input  1  system pixel clock; the block has exactly one clock.
REQ-004 resetN  input  1  asynchronous active-low reset.
REQ-005 startOfFrame  input  1  one-cycle pulse at the start of each video frame.
REQ-006 drawing_request_player  input  1  player sprite pixel active.
REQ-007 drawing_request_enemy  input  1  enemy sprite pixel active.
REQ-008 drawing_request_fruit  input  1  fruit sprite pixel active.
REQ-009 drawing_request_goal  input  1  goal/key sprite pixel active.
REQ-010 drawing_request_platform  input  1  platform/vine pixel active.
REQ-011 event_ack  input  1  consumer accepts the presented event.
REQ-012 event_valid  output  1  an event is presented on event_code.
REQ-013 event_code  output  2  1=DEATH, 2=FRUIT, 3=GOAL, 0=none.
REQ-014 platform_contact  output  1  player touched platform during the previous complete frame.
REQ-015 overrun_pulse  output  1  one-cycle pulse: new frame snapshot arrived while events were still pending.
REQ-016 timeout_pulse  output  1  one-cycle pulse: presented event dropped for lack of ack.
REQ-017 immune  output  1  enemy-collision cooldown is active.

Function
REQ-018 Every clk cycle, each sticky flag (death, fruit, goal, platform) SHALL be set when drawing_request_player and the matching object request are both 1 in that cycle.
REQ-019 The death sticky flag SHALL NOT be set while immune=1.
REQ-020 On startOfFrame the sticky flags SHALL be OR-ed into the pending register (death/fruit/goal) and platform_contact loaded from the platform flag, then all sticky flags cleared; a collision in the startOfFrame cycle itself SHALL be counted in the new frame.
REQ-021 If any pending bit is already 1 when startOfFrame loads a non-zero snapshot, overrun_pulse SHALL be 1 the following cycle; pending bits merge, none are lost.
REQ-022 FSM states: IDLE, PRESENT. IDLE->PRESENT in the cycle after pending becomes non-zero; PRESENT->IDLE when pending becomes zero.
REQ-023 In PRESENT, event_valid=1 and event_code SHALL show the highest-priority pending bit: GOAL > DEATH > FRUIT; event_code SHALL be stable while event_valid=1 and not acknowledged.
REQ-024 event_ack sampled 1 with event_valid=1 SHALL clear that pending bit; the next pending event SHALL be presented no earlier than the following cycle (event_valid deasserts for exactly one cycle between events).
REQ-025 event_ack while event_valid=0 SHALL be ignored.
REQ-026 A 5-bit wait counter SHALL reset on each new presentation and increment each unacknowledged PRESENT cycle; reaching ACK_TIMEOUT SHALL clear the presented bit and pulse timeout_pulse for one cycle.
REQ-027 Acknowledging DEATH SHALL load a 6-bit cooldown counter with COOLDOWN_FRAMES; it SHALL decrement on each startOfFrame, saturating at 0; immune=1 while counter != 0. COOLDOWN_FRAMES=0 SHALL yield no immunity.
REQ-028 A timed-out DEATH SHALL NOT start the cooldown.
REQ-029 startOfFrame coinciding with event_ack SHALL apply both: the acked bit is cleared and snapshot bits merged; an acked bit re-set by the snapshot SHALL be presented again.

Reset
REQ-030 resetN=0 SHALL immediately clear all sticky flags, pending register, counters, FSM to IDLE, and drive event_valid=0, event_code=0, platform_contact=0, overrun_pulse=0, timeout_pulse=0, immune=0, regardless of clk.
REQ-031 Reset asserted mid-presentation SHALL discard the pending event without any pulse; after release the block waits for the next startOfFrame.

Verification
REQ-032 Player+fruit overlap 3 cycles in frame N, startOfFrame -> event_valid=1, event_code=2 next cycle; ack -> event_valid=0, no further events.
REQ-033 Player overlaps goal, enemy and fruit in one frame -> codes presented in order 3,1,2, each separated by one idle cycle, acks given immediately.
REQ-034 DEATH presented, event_ack held 0 for 16 cycles -> timeout_pulse=1 once, event_valid=0, immune stays 0.
REQ-035 DEATH acked, COOLDOWN_FRAMES=2 -> immune=1; enemy overlap in next two frames produces no event; after 2 startOfFrame pulses immune=0 and next overlap produces code 1.
REQ-036 FRUIT pending unacked, new frame with goal overlap -> overrun_pulse=1 one cycle, then code 3 then code 2 presented.
REQ-037 resetN pulsed low while event_valid=1 -> all outputs 0 asynchronously; no event until next frame with a collision.

Source files
------------

// File: rtl/collision_event_arbiter.sv
// Collision event arbiter: per-frame sticky collision capture, prioritised
// event presentation with ack/timeout, and post-death enemy immunity.
module collision_event_arbiter #(
    parameter int ACK_TIMEOUT     = 16,
    parameter int COOLDOWN_FRAMES = 30
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       drawing_request_player,
    input  logic       drawing_request_enemy,
    input  logic       drawing_request_fruit,
    input  logic       drawing_request_goal,
    input  logic       drawing_request_platform,
    input  logic       event_ack,
    output logic       event_valid,
    output logic [1:0] event_code,
    output logic       platform_contact,
    output logic       overrun_pulse,
    output logic       timeout_pulse,
    output logic       immune
);

    typedef enum logic {IDLE, PRESENT} state_t;

    localparam logic [4:0] WAIT_LAST = 5'(ACK_TIMEOUT - 1);
    localparam logic [5:0] COOL_LOAD = 6'(COOLDOWN_FRAMES);

    // pending / sticky bit order: [2]=goal, [1]=fruit, [0]=death
    state_t     state, state_n;
    logic       st_death, st_fruit, st_goal, st_plat;
    logic       hit_death, hit_fruit, hit_goal, hit_plat;
    logic [2:0] pend, pend_n, snap, clr;
    logic [1:0] code_q, code_n, pick;
    logic [4:0] wcnt, wcnt_n;
    logic [5:0] cool;
    logic       ack_v, tmo, rearb;

    assign hit_death = drawing_request_player & drawing_request_enemy & ~immune;
    assign hit_fruit = drawing_request_player & drawing_request_fruit;
    assign hit_goal  = drawing_request_player & drawing_request_goal;
    assign hit_plat  = drawing_request_player & drawing_request_platform;

    assign snap        = {st_goal, st_fruit, st_death};
    assign immune      = (cool != 6'd0);
    assign event_valid = (state == PRESENT);
    assign event_code  = event_valid ? code_q : 2'd0;
    assign ack_v       = event_valid & event_ack;
    assign tmo         = event_valid & ~event_ack & (wcnt == WAIT_LAST);
    // a fresh snapshot during a presentation forces re-arbitration
    assign rearb       = startOfFrame & (snap != 3'd0);

    // Bit to drop when the presented event is acked or times out
    always_comb begin
        clr = 3'b000;
        if (ack_v || tmo) begin
            case (code_q)
                2'd1:    clr = 3'b001;
                2'd2:    clr = 3'b010;
                2'd3:    clr = 3'b100;
                default: clr = 3'b000;
            endcase
        end
        pend_n = (pend & ~clr) | (startOfFrame ? snap : 3'b000);
    end

    // Priority pick on next pending: goal > death > fruit
    always_comb begin
        pick = 2'd0;
        if (pend_n[2])      pick = 2'd3;
        else if (pend_n[0]) pick = 2'd1;
        else if (pend_n[1]) pick = 2'd2;
    end

    // Next-state, latched code and wait counter
    always_comb begin
        state_n = state;
        code_n  = code_q;
        wcnt_n  = wcnt;
        case (state)
            IDLE: begin
                if (pend_n != 3'd0) begin
                    state_n = PRESENT;
                    code_n  = pick;
                    wcnt_n  = 5'd0;
                end
            end
            PRESENT: begin
                if (ack_v || tmo || rearb) state_n = IDLE;
                else                       wcnt_n  = wcnt + 5'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    // Sticky flags; a startOfFrame-cycle hit belongs to the new frame
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            st_death <= 1'b0;
            st_fruit <= 1'b0;
            st_goal  <= 1'b0;
            st_plat  <= 1'b0;
        end else if (startOfFrame) begin
            st_death <= hit_death;
            st_fruit <= hit_fruit;
            st_goal  <= hit_goal;
            st_plat  <= hit_plat;
        end else begin
            st_death <= st_death | hit_death;
            st_fruit <= st_fruit | hit_fruit;
            st_goal  <= st_goal  | hit_goal;
            st_plat  <= st_plat  | hit_plat;
        end
    end

    // Pending register, FSM state and presentation bookkeeping
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state  <= IDLE;
            pend   <= 3'd0;
            code_q <= 2'd0;
            wcnt   <= 5'd0;
        end else begin
            state  <= state_n;
            pend   <= pend_n;
            code_q <= code_n;
            wcnt   <= wcnt_n;
        end
    end

    // Frame-level outputs and one-cycle pulses
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            platform_contact <= 1'b0;
            overrun_pulse    <= 1'b0;
            timeout_pulse    <= 1'b0;
        end else begin
            if (startOfFrame) platform_contact <= st_plat;
            overrun_pulse <= startOfFrame & (pend != 3'd0) & (snap != 3'd0);
            timeout_pulse <= tmo;
        end
    end

    // Cooldown: loaded by an acked death, counts frames down to zero
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cool <= 6'd0;
        end else if (ack_v && code_q == 2'd1) begin
            cool <= COOL_LOAD;
        end else if (startOfFrame && cool != 6'd0) begin
            cool <= cool - 6'd1;
        end
    end

endmodule

// File: tb/tb_collision_event_arbiter.sv
// Directed bench for collision_event_arbiter: vector table for the main
// event flow plus hand-written timeout, overrun, ack/frame and reset cases.
module tb_collision_event_arbiter;

    localparam logic [6:0] SOF = 7'b1000000;
    localparam logic [6:0] PL  = 7'b0100000;
    localparam logic [6:0] EN  = 7'b0010000;
    localparam logic [6:0] FR  = 7'b0001000;
    localparam logic [6:0] GO  = 7'b0000100;
    localparam logic [6:0] PF  = 7'b0000010;
    localparam logic [6:0] AK  = 7'b0000001;
    localparam logic [6:0] NO  = 7'b0000000;

    typedef struct packed {
        logic [6:0] in;
        logic [6:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame, drawing_request_player, drawing_request_enemy;
    logic       drawing_request_fruit, drawing_request_goal;
    logic       drawing_request_platform, event_ack;
    logic       event_valid;
    logic [1:0] event_code;
    logic       platform_contact, overrun_pulse, timeout_pulse, immune;

    int checks = 0;
    int errors = 0;
    vec_t tbl [22];

    always #5 clk = ~clk;

    collision_event_arbiter #(.ACK_TIMEOUT(16), .COOLDOWN_FRAMES(2)) dut (
        .clk(clk),
        .resetN(resetN),
        .startOfFrame(startOfFrame),
        .drawing_request_player(drawing_request_player),
        .drawing_request_enemy(drawing_request_enemy),
        .drawing_request_fruit(drawing_request_fruit),
        .drawing_request_goal(drawing_request_goal),
        .drawing_request_platform(drawing_request_platform),
        .event_ack(event_ack),
        .event_valid(event_valid),
        .event_code(event_code),
        .platform_contact(platform_contact),
        .overrun_pulse(overrun_pulse),
        .timeout_pulse(timeout_pulse),
        .immune(immune)
    );

    // {valid, code, platform, overrun, timeout, immune}
    function automatic logic [6:0] ex(input logic v, input logic [1:0] c,
                                      input logic p, input logic ov,
                                      input logic to, input logic im);
        return {v, c, p, ov, to, im};
    endfunction

    task automatic set_in(input logic [6:0] i);
        {startOfFrame, drawing_request_player, drawing_request_enemy,
         drawing_request_fruit, drawing_request_goal,
         drawing_request_platform, event_ack} = i;
    endtask

    task automatic check(input string name, input logic [6:0] e);
        logic [6:0] a;
        a = {event_valid, event_code, platform_contact,
             overrun_pulse, timeout_pulse, immune};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got v/code/plat/ovr/tmo/imm=%b required %b",
                     name, a, e);
        end
    endtask

    // drive at negedge, sample 1 time unit after the following posedge
    task automatic cyc(input logic [6:0] i, input string name,
                       input logic [6:0] e);
        @(negedge clk);
        set_in(i);
        @(posedge clk);
        #1;
        check(name, e);
    endtask

    initial begin
        tbl[0]  = '{SOF,         ex(0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{PL | FR,     ex(0, 0, 0, 0, 0, 0)};
        tbl[2]  = '{PL | FR,     ex(0, 0, 0, 0, 0, 0)};
        tbl[3]  = '{PL | FR,     ex(0, 0, 0, 0, 0, 0)};
        tbl[4]  = '{AK,          ex(0, 0, 0, 0, 0, 0)};
        tbl[5]  = '{SOF,         ex(1, 2, 0, 0, 0, 0)};
        tbl[6]  = '{NO,          ex(1, 2, 0, 0, 0, 0)};
        tbl[7]  = '{AK,          ex(0, 0, 0, 0, 0, 0)};
        tbl[8]  = '{NO,          ex(0, 0, 0, 0, 0, 0)};
        tbl[9]  = '{PL | GO | EN | FR | PF, ex(0, 0, 0, 0, 0, 0)};
        tbl[10] = '{SOF,         ex(1, 3, 1, 0, 0, 0)};
        tbl[11] = '{AK,          ex(0, 0, 1, 0, 0, 0)};
        tbl[12] = '{AK,          ex(1, 1, 1, 0, 0, 0)};
        tbl[13] = '{AK,          ex(0, 0, 1, 0, 0, 1)};
        tbl[14] = '{NO,          ex(1, 2, 1, 0, 0, 1)};
        tbl[15] = '{AK,          ex(0, 0, 1, 0, 0, 1)};
        tbl[16] = '{PL | EN,     ex(0, 0, 1, 0, 0, 1)};
        tbl[17] = '{SOF,         ex(0, 0, 0, 0, 0, 1)};
        tbl[18] = '{PL | EN,     ex(0, 0, 0, 0, 0, 1)};
        tbl[19] = '{SOF,         ex(0, 0, 0, 0, 0, 0)};
        tbl[20] = '{PL | EN,     ex(0, 0, 0, 0, 0, 0)};
        tbl[21] = '{SOF,         ex(1, 1, 0, 0, 0, 0)};

        set_in(NO);
        resetN = 1'b0;
        #12;
        check("reset_state", ex(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        resetN = 1'b1;

        for (int i = 0; i < 22; i++)
            cyc(tbl[i].in, $sformatf("vec%0d", i), tbl[i].exp);

        // unacked death presented for 16 cycles then dropped
        for (int k = 1; k < 16; k++)
            cyc(NO, $sformatf("tmo_wait%0d", k), ex(1, 1, 0, 0, 0, 0));
        cyc(NO, "tmo_pulse", ex(0, 0, 0, 0, 1, 0));
        cyc(NO, "tmo_after", ex(0, 0, 0, 0, 0, 0));

        // fruit presented, goal arrives next frame: overrun and re-order
        cyc(PL | FR, "ovr_a", ex(0, 0, 0, 0, 0, 0));
        cyc(SOF,     "ovr_b", ex(1, 2, 0, 0, 0, 0));
        cyc(PL | GO, "ovr_c", ex(1, 2, 0, 0, 0, 0));
        cyc(SOF,     "ovr_d", ex(0, 0, 0, 1, 0, 0));
        cyc(NO,      "ovr_e", ex(1, 3, 0, 0, 0, 0));
        cyc(AK,      "ovr_f", ex(0, 0, 0, 0, 0, 0));
        cyc(NO,      "ovr_g", ex(1, 2, 0, 0, 0, 0));
        cyc(AK,      "ovr_h", ex(0, 0, 0, 0, 0, 0));
        cyc(NO,      "ovr_i", ex(0, 0, 0, 0, 0, 0));

        // ack coinciding with a frame that re-sets the same bit
        cyc(PL | FR,   "ackf_a", ex(0, 0, 0, 0, 0, 0));
        cyc(SOF,       "ackf_b", ex(1, 2, 0, 0, 0, 0));
        cyc(PL | FR,   "ackf_c", ex(1, 2, 0, 0, 0, 0));
        cyc(SOF | AK,  "ackf_d", ex(0, 0, 0, 1, 0, 0));
        cyc(NO,        "ackf_e", ex(1, 2, 0, 0, 0, 0));
        cyc(AK,        "ackf_f", ex(0, 0, 0, 0, 0, 0));
        cyc(NO,        "ackf_g", ex(0, 0, 0, 0, 0, 0));

        // asynchronous reset mid-presentation
        cyc(PL | GO | PF, "rst_a", ex(0, 0, 0, 0, 0, 0));
        cyc(SOF,          "rst_b", ex(1, 3, 1, 0, 0, 0));
        cyc(PL | FR,      "rst_c", ex(1, 3, 1, 0, 0, 0));
        @(negedge clk);
        set_in(NO);
        #2;
        resetN = 1'b0;
        #1;
        check("rst_async", ex(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;
        cyc(NO,      "rst_d", ex(0, 0, 0, 0, 0, 0));
        cyc(SOF,     "rst_e", ex(0, 0, 0, 0, 0, 0));
        cyc(PL | EN, "rst_f", ex(0, 0, 0, 0, 0, 0));
        cyc(SOF,     "rst_g", ex(1, 1, 0, 0, 0, 0));
        cyc(AK,      "rst_h", ex(0, 0, 0, 0, 0, 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
